counter_step_arbiter: RTL and testbench

//   Shares one Counter_dual (+1/+2/-1 step counter) among three requesters: up1, up2, down.

---
 rtl/counter_ctrl_pkg.sv | 23 ++
 rtl/rr_arbiter3.sv | 51 +++++
 rtl/counter_step_arbiter.sv | 167 ++++++++++++++++
 tb/tb_counter_step_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter step arbiter: FSM state encodings,
// requester indices and the round-robin successor helper.
package counter_ctrl_pkg;

    localparam int unsigned IDX_W   = 2;
    localparam int unsigned NUM_REQ = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] REQ_UP1 = 2'd0;
    localparam logic [IDX_W-1:0] REQ_UP2 = 2'd1;
    localparam logic [IDX_W-1:0] REQ_DN  = 2'd2;

    // Round-robin successor: up1 -> up2 -> dn -> up1
    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx);
        return (idx == REQ_DN) ? REQ_UP1 : IDX_W'(idx + 2'd1);
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-input round-robin arbiter: combinational grant from the request
// vector and a registered priority pointer that advances past the winner.
module rr_arbiter3
    import counter_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    input  logic [IDX_W-1:0]   adv_idx_i,
    output logic               gnt_vld_c_o,
    output logic [IDX_W-1:0]   gnt_idx_c_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] cand1, cand2;
    logic [NUM_REQ:0] req_pad;

    // Padding keeps every 2-bit index in range of the request vector
    assign req_pad = {1'b0, req_i};

    always_comb begin
        cand1       = rr_next(ptr_q);
        cand2       = rr_next(cand1);
        gnt_vld_c_o = |req_i;
        gnt_idx_c_o = ptr_q;
        if (req_pad[ptr_q]) begin
            gnt_idx_c_o = ptr_q;
        end else if (req_pad[cand1]) begin
            gnt_idx_c_o = cand1;
        end else if (req_pad[cand2]) begin
            gnt_idx_c_o = cand2;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = rr_next(adv_idx_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= REQ_UP1;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/counter_step_arbiter.sv
// Shares one +1/+2/-1 step counter among three requesters with a
// round-robin req/ack handshake and a shadow count. CNT_SAT_EN refuses
// steps that would cross 0 or MAX instead of wrapping.
module counter_step_arbiter
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             req_up1,
    input  logic             req_up2,
    input  logic             req_dn,
    output logic             ack_up1,
    output logic             ack_up2,
    output logic             ack_dn,
    output logic             err,
    output logic             en1,
    output logic             en2,
    output logic             en_d,
    output logic             cnt_clr,
    output logic [WIDTH-1:0] count,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] win_q, win_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic ack_up1_q, ack_up1_d, ack_up2_q, ack_up2_d, ack_dn_q, ack_dn_d;
    logic en1_q, en1_d, en2_q, en2_d, en_d_q, en_d_d;
    logic err_q, err_d, cnt_clr_q, cnt_clr_d, busy_q, busy_d;
    logic             gnt_vld_c;
    logic [IDX_W-1:0] gnt_idx_c;
    logic             refuse_c;
    logic             advance_c;

    // Pointer moves only when a grant actually completes; clr keeps it
    assign advance_c = (state_q == ST_ISSUE) && !clr;

    rr_arbiter3 u_arb (
        .clk         (clk),
        .rst_n       (rst),
        .req_i       ({req_dn, req_up2, req_up1}),
        .advance_i   (advance_c),
        .adv_idx_i   (win_q),
        .gnt_vld_c_o (gnt_vld_c),
        .gnt_idx_c_o (gnt_idx_c)
    );

`ifdef CNT_SAT_EN
    localparam logic [WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [WIDTH-1:0] CNT_MAX_M1 = CNT_MAX - WIDTH'(1);

    always_comb begin
        refuse_c = ((gnt_idx_c == REQ_UP1) && (count_q == CNT_MAX))    ||
                   ((gnt_idx_c == REQ_UP2) && (count_q >= CNT_MAX_M1)) ||
                   ((gnt_idx_c == REQ_DN)  && (count_q == '0));
    end
`else
    assign refuse_c = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            win_q   <= REQ_UP1;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        if (clr) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (gnt_vld_c) begin
                        state_d = ST_ISSUE;
                        win_d   = gnt_idx_c;
                    end
                end
                ST_ISSUE: state_d = ST_GAP;
                ST_GAP:   state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Grant outputs are decided in IDLE so they appear during ISSUE
    always_comb begin
        ack_up1_d = 1'b0;
        ack_up2_d = 1'b0;
        ack_dn_d  = 1'b0;
        en1_d     = 1'b0;
        en2_d     = 1'b0;
        en_d_d    = 1'b0;
        err_d     = 1'b0;
        cnt_clr_d = clr;
        busy_d    = (state_d != ST_IDLE);
        count_d   = count_q;
        if (clr) begin
            count_d = '0;
        end else begin
            if ((state_q == ST_IDLE) && gnt_vld_c) begin
                ack_up1_d = (gnt_idx_c == REQ_UP1);
                ack_up2_d = (gnt_idx_c == REQ_UP2);
                ack_dn_d  = (gnt_idx_c == REQ_DN);
                err_d     = refuse_c;
                en1_d     = (gnt_idx_c == REQ_UP1) && !refuse_c;
                en2_d     = (gnt_idx_c == REQ_UP2) && !refuse_c;
                en_d_d    = (gnt_idx_c == REQ_DN)  && !refuse_c;
            end
            if (state_q == ST_ISSUE) begin
                if (en1_q) begin
                    count_d = count_q + WIDTH'(1);
                end else if (en2_q) begin
                    count_d = count_q + WIDTH'(2);
                end else if (en_d_q) begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_up1_q <= 1'b0;
            ack_up2_q <= 1'b0;
            ack_dn_q  <= 1'b0;
            en1_q     <= 1'b0;
            en2_q     <= 1'b0;
            en_d_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_clr_q <= 1'b0;
            busy_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            ack_up1_q <= ack_up1_d;
            ack_up2_q <= ack_up2_d;
            ack_dn_q  <= ack_dn_d;
            en1_q     <= en1_d;
            en2_q     <= en2_d;
            en_d_q    <= en_d_d;
            err_q     <= err_d;
            cnt_clr_q <= cnt_clr_d;
            busy_q    <= busy_d;
            count_q   <= count_d;
        end
    end

    assign ack_up1 = ack_up1_q;
    assign ack_up2 = ack_up2_q;
    assign ack_dn  = ack_dn_q;
    assign en1     = en1_q;
    assign en2     = en2_q;
    assign en_d    = en_d_q;
    assign err     = err_q;
    assign cnt_clr = cnt_clr_q;
    assign busy    = busy_q;
    assign count   = count_q;

endmodule

// File: tb/tb_counter_step_arbiter.sv
// Directed bench for counter_step_arbiter: vector table for round-robin
// ordering plus hand sequences for reset, wrap/saturation (CNT_SAT_EN), clr.
module tb_counter_step_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       req_up1, req_up2, req_dn;
    logic       ack_up1, ack_up2, ack_dn, err;
    logic       en1, en2, en_d, cnt_clr, busy;
    logic [3:0] count;

    int checks = 0;
    int errors = 0;
    logic [3:0] cur;

    localparam logic [8:0] F_EN1  = 9'b100000000;
    localparam logic [8:0] F_EN2  = 9'b010000000;
    localparam logic [8:0] F_END  = 9'b001000000;
    localparam logic [8:0] F_A1   = 9'b000100000;
    localparam logic [8:0] F_A2   = 9'b000010000;
    localparam logic [8:0] F_AD   = 9'b000001000;
    localparam logic [8:0] F_ERR  = 9'b000000100;
    localparam logic [8:0] F_CLR  = 9'b000000010;
    localparam logic [8:0] F_BUSY = 9'b000000001;

    typedef struct {
        logic [2:0] req;
        logic       clr;
        logic [8:0] flags;
        logic [3:0] cnt;
    } vec_t;

    vec_t tbl [13];

    counter_step_arbiter #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .req_up1 (req_up1),
        .req_up2 (req_up2),
        .req_dn  (req_dn),
        .ack_up1 (ack_up1),
        .ack_up2 (ack_up2),
        .ack_dn  (ack_dn),
        .err     (err),
        .en1     (en1),
        .en2     (en2),
        .en_d    (en_d),
        .cnt_clr (cnt_clr),
        .count   (count),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [8:0] exp_f, input logic [3:0] exp_c);
        logic [8:0] act;
        act = {en1, en2, en_d, ack_up1, ack_up2, ack_dn, err, cnt_clr, busy};
        checks++;
        if (act !== exp_f || count !== exp_c) begin
            errors++;
            $display("FAIL %s: flags=%b count=%0d, expected flags=%b count=%0d",
                     name, act, count, exp_f, exp_c);
        end
    endtask

    // One full req/ack transaction; idx 0=up1 1=up2 2=dn
    task automatic grant(input string name, input logic [2:0] reqv, input int idx,
                         input logic exp_err, input logic [3:0] exp_after);
        logic [8:0] f;
        {req_dn, req_up2, req_up1} = reqv;
        tick;
        f = F_BUSY;
        case (idx)
            0:       f = f | F_A1 | (exp_err ? F_ERR : F_EN1);
            1:       f = f | F_A2 | (exp_err ? F_ERR : F_EN2);
            default: f = f | F_AD | (exp_err ? F_ERR : F_END);
        endcase
        check({name, "_issue"}, f, cur);
        {req_dn, req_up2, req_up1} = 3'b000;
        tick;
        check({name, "_gap"}, F_BUSY, exp_after);
        tick;
        check({name, "_idle"}, 9'b0, exp_after);
        cur = exp_after;
    endtask

    initial begin
        tbl[0]  = '{3'b000, 1'b0, 9'b0,                 4'd0};
        tbl[1]  = '{3'b111, 1'b0, F_EN1 | F_A1 | F_BUSY, 4'd0};
        tbl[2]  = '{3'b111, 1'b0, F_BUSY,               4'd1};
        tbl[3]  = '{3'b111, 1'b0, 9'b0,                 4'd1};
        tbl[4]  = '{3'b111, 1'b0, F_EN2 | F_A2 | F_BUSY, 4'd1};
        tbl[5]  = '{3'b111, 1'b0, F_BUSY,               4'd3};
        tbl[6]  = '{3'b111, 1'b0, 9'b0,                 4'd3};
        tbl[7]  = '{3'b111, 1'b0, F_END | F_AD | F_BUSY, 4'd3};
        tbl[8]  = '{3'b111, 1'b0, F_BUSY,               4'd2};
        tbl[9]  = '{3'b111, 1'b0, 9'b0,                 4'd2};
        tbl[10] = '{3'b111, 1'b0, F_EN1 | F_A1 | F_BUSY, 4'd2};
        tbl[11] = '{3'b111, 1'b0, F_BUSY,               4'd3};
        tbl[12] = '{3'b000, 1'b0, 9'b0,                 4'd3};

        rst = 1'b0; clr = 1'b0;
        req_up1 = 1'b0; req_up2 = 1'b0; req_dn = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        tick;
        check("reset_state", 9'b0, 4'd0);

        // Async reset while a grant is in ISSUE: no ack survives
        req_up1 = 1'b1;
        tick;
        check("pre_reset_issue", F_EN1 | F_A1 | F_BUSY, 4'd0);
        rst = 1'b0;
        #1;
        check("reset_mid_issue", 9'b0, 4'd0);
        req_up1 = 1'b0;
        tick;
        rst = 1'b1;
        tick;

        for (int i = 0; i < 13; i++) begin
            {req_dn, req_up2, req_up1} = tbl[i].req;
            clr = tbl[i].clr;
            tick;
            check($sformatf("rr_vec%0d", i), tbl[i].flags, tbl[i].cnt);
        end
        cur = 4'd3;

`ifdef CNT_SAT_EN
        for (int i = 0; i < 5; i++) grant($sformatf("up2_%0d", i), 3'b010, 1, 1'b0, 4'(cur + 4'd2));
        grant("up1_to14", 3'b001, 0, 1'b0, 4'd14);
        grant("sat_up2_at14", 3'b010, 1, 1'b1, 4'd14);
        grant("up1_to15", 3'b001, 0, 1'b0, 4'd15);
        grant("sat_up1_at15", 3'b001, 0, 1'b1, 4'd15);
`else
        for (int i = 0; i < 6; i++) grant($sformatf("up2_%0d", i), 3'b010, 1, 1'b0, 4'(cur + 4'd2));
        grant("wrap_up2_at15", 3'b010, 1, 1'b0, 4'd1);
`endif

        // Clear while idle
        clr = 1'b1;
        tick;
        check("clr_idle", F_CLR, 4'd0);
        clr = 1'b0;
        tick;
        check("clr_idle_after", 9'b0, 4'd0);
        cur = 4'd0;

        grant("up1_after_clr", 3'b001, 0, 1'b0, 4'd1);

        // Clear during ISSUE discards the dn step and keeps the pointer at up2
        req_dn = 1'b1;
        tick;
        check("clr_issue_pre", F_END | F_AD | F_BUSY, 4'd1);
        clr = 1'b1;
        req_dn = 1'b0;
        tick;
        check("clr_during_issue", F_CLR, 4'd0);
        clr = 1'b0;
        tick;
        check("clr_issue_after", 9'b0, 4'd0);
        cur = 4'd0;

        grant("ptr_kept_up2", 3'b111, 1, 1'b0, 4'd2);
        grant("dn_to1", 3'b100, 2, 1'b0, 4'd1);
        grant("dn_to0", 3'b100, 2, 1'b0, 4'd0);
`ifdef CNT_SAT_EN
        grant("sat_dn_at0", 3'b100, 2, 1'b1, 4'd0);
`else
        grant("wrap_dn_at0", 3'b100, 2, 1'b0, 4'd15);
`endif

        // Request raised and withdrawn before the sampling edge
        #2;
        req_up1 = 1'b1;
        #2;
        req_up1 = 1'b0;
        tick;
        check("withdrawn_req", 9'b0, cur);
        tick;
        check("withdrawn_req2", 9'b0, cur);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
